decode_queue: RTL and testbench
===============================

// Module: decode_queue
// PURPOSE
//  Decoded-instruction queue between fetch and execute. Each instruction is decoded
//  to an rv32i_control word when it is pushed. The control word is stored with its
//  instr/pc in a DEPTH-entry circular buffer and popped with a valid/ready handshake.
//  Adds over the flat decoder: buffering, flush, M-extension gating and illegal-instruction flagging.
// PARAMETERS
//  DEPTH  4   entries; power of two, >= 2
//  M_EXT  1   1: decode RV32M (op_reg, funct7=0000001); 0: flag those encodings illegal
//  XLEN   32  pc width
// PORTS
//  clk          in   1                    clock, rising edge
//  rst_n        in   1                    asynchronous reset, active-low
//  flush        in   1                    synchronous queue clear
//  in_valid     in   1                    push request
//  in_ready     out  1                    queue can accept (not full)
//  in_instr     in   32                   raw instruction
//  in_pc        in   XLEN                 instruction pc
//  out_valid    out  1                    head entry valid
//  out_ready    in   1                    consumer accepts head
//  out_ctrl     out  $bits(rv32i_control) decoded head control word
//  out_instr    out  32                   head raw instruction
//  out_pc       out  XLEN                 head pc
//  out_illegal  out  1                    head instruction is illegal
//  count        out  $clog2(DEPTH+1)      occupancy
// BEHAVIOUR
//  Reset: rd/wr ptr=0, count=0; out_valid=0, in_ready=1. out_ctrl/instr/pc/illegal=0 while empty.
//  push = in_valid & in_ready; pop = out_valid & out_ready; both take effect at the clk edge.
//  in_ready = (count != DEPTH). It depends only on state, never on out_ready.
//  Full: push is blocked even if a pop happens in the same cycle.
//  out_valid = (count != 0). Outputs come straight from storage, with no comb path from in_* to out_*.
//  Push+pop in the same cycle (not full, not empty): count is unchanged and both ptrs advance.
//  Pop with push on an empty queue: the pop cannot occur. The pushed entry appears next cycle (latency 1).
//  Pointers wrap modulo DEPTH.
//  flush: count and ptrs go to 0 next edge. It overrides push and pop in the same cycle. Nothing is stored.
//  Async reset during traffic clears all state immediately. Entries in flight are lost.
//  Decode (combinational from in_instr, written into the entry on push):
//   defaults: opcode/funct3 copied; load_regfile=0; alumux rs1_out/i_imm; regfilemux alu_out;
//     cmpmux rs2_out; cmpop beq; aluop=funct3; icache_read=1; every other enable 0.
//   lui: load u_imm. auipc: alu pc+u_imm, load alu_out.
//   jal: alu pc+j_imm, load pc_plus4, jal_enable. jalr: alu rs1+i_imm, load pc_plus4, jalr_enable.
//   br: cmpop=funct3, alu pc+b_imm, branch_enable.
//   load: alu rs1+i_imm, dcache_read, regfilemux lb/lh/lw/lbu/lhu by funct3.
//   store: alu rs1+s_imm, dcache_write.
//   imm/reg ALU ops: aluop by funct3. funct7=0100000 selects sub (reg add) or sra.
//   slt/sltu (imm, reg): cmpop blt/bltu, cmpmux i_imm (imm) or rs2_out (reg), load br_en, forward_cmp.
//   reg, funct7=0000001, M_EXT=1: m_enable=1, alumux rs1/rs2, load alu_out, forward_cmp=0.
//  Illegal (out_illegal=1; stored ctrl is all-zero except opcode/funct3; entry still queued in order):
//   opcode not in {lui,auipc,jal,jalr,br,load,store,imm,reg}.
//   br funct3 010/011. load funct3 011/110/111. store funct3 > 010.
//   imm slli funct7!=0; srli/srai funct7 not in {0,0100000}.
//   reg funct7 not in {0, 0100000 (add/sr only), 0000001 (M_EXT=1 only)}.
// TESTING
//  1 reset; push 0x00500093 (addi x1,x0,5) -> next cycle out_valid=1, aluop=alu_add, load_regfile=1, count=1.
//  2 out_ready=0; push DEPTH instrs -> in_ready=0 at count=DEPTH.
//    Then 1 pop+1 push -> push blocked. Drain -> original order, ptr wrap OK.
//  3 count=2; push+pop same cycle for 8 cycles -> count stays 2, FIFO order kept, pcs match.
//  4 push 0xFFFFFFFF -> out_illegal=1, load_regfile=0, dcache_read/write=0, still pops in order.
//  5 push 0x022081B3 (mul x3,x1,x2) -> M_EXT=1: m_enable=1, out_illegal=0; M_EXT=0: out_illegal=1.
//  6 3 entries queued; flush with in_valid=1 -> next cycle count=0, out_valid=0, pushed instr dropped.
//    Also assert rst_n=0 mid-stream -> outputs clear immediately.

Source files
------------

// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
//  Module   : decode_queue (with package decode_queue_pkg)
//  Purpose  : Decoded-instruction queue between fetch and execute. Each
//             pushed instruction is decoded to an rv32i_control word and
//             stored with its instr/pc in a circular buffer. Entries are
//             popped with a valid/ready handshake. Illegal encodings are
//             flagged and still queued in program order.
//  Revision : 1.0  initial release
// ============================================================================

package decode_queue_pkg;

    // Major opcodes
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_CSR   = 7'b1110011;

    // ALU operation select
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SLL = 3'b001;
    localparam logic [2:0] ALU_SRA = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    // Comparator operation select (same encoding as branch funct3)
    localparam logic [2:0] CMP_BEQ  = 3'b000;
    localparam logic [2:0] CMP_BNE  = 3'b001;
    localparam logic [2:0] CMP_BLT  = 3'b100;
    localparam logic [2:0] CMP_BGE  = 3'b101;
    localparam logic [2:0] CMP_BLTU = 3'b110;
    localparam logic [2:0] CMP_BGEU = 3'b111;

    // ALU operand muxes
    localparam logic       ALUMUX1_RS1 = 1'b0;
    localparam logic       ALUMUX1_PC  = 1'b1;
    localparam logic [2:0] ALUMUX2_I   = 3'd0;
    localparam logic [2:0] ALUMUX2_U   = 3'd1;
    localparam logic [2:0] ALUMUX2_B   = 3'd2;
    localparam logic [2:0] ALUMUX2_S   = 3'd3;
    localparam logic [2:0] ALUMUX2_J   = 3'd4;
    localparam logic [2:0] ALUMUX2_RS2 = 3'd5;

    // Comparator operand mux
    localparam logic       CMPMUX_RS2 = 1'b0;
    localparam logic       CMPMUX_I   = 1'b1;

    // Register-file write-data mux
    localparam logic [3:0] RFMUX_ALU   = 4'd0;
    localparam logic [3:0] RFMUX_BR_EN = 4'd1;
    localparam logic [3:0] RFMUX_U_IMM = 4'd2;
    localparam logic [3:0] RFMUX_LW    = 4'd3;
    localparam logic [3:0] RFMUX_PC4   = 4'd4;
    localparam logic [3:0] RFMUX_LB    = 4'd5;
    localparam logic [3:0] RFMUX_LBU   = 4'd6;
    localparam logic [3:0] RFMUX_LH    = 4'd7;
    localparam logic [3:0] RFMUX_LHU   = 4'd8;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [2:0] aluop;
        logic [2:0] cmpop;
        logic       alumux1_sel;
        logic [2:0] alumux2_sel;
        logic       cmpmux_sel;
        logic [3:0] regfilemux_sel;
        logic       load_regfile;
        logic       icache_read;
        logic       dcache_read;
        logic       dcache_write;
        logic       jal_enable;
        logic       jalr_enable;
        logic       branch_enable;
        logic       forward_cmp;
        logic       m_enable;
    } rv32i_control;

endpackage

module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int M_EXT = 1,
    parameter int XLEN  = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [31:0]                      in_instr,
    input  logic [XLEN-1:0]                  in_pc,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [$bits(rv32i_control)-1:0]  out_ctrl,
    output logic [31:0]                      out_instr,
    output logic [XLEN-1:0]                  out_pc,
    output logic                             out_illegal,
    output logic [$clog2(DEPTH+1)-1:0]       count
);

    localparam int              PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW         = $clog2(DEPTH+1);
    localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);

    // ------------------------------------------------------------------
    // Decoder
    // ------------------------------------------------------------------
    logic [6:0]   dec_opcode;
    logic [2:0]   dec_funct3;
    logic [6:0]   dec_funct7;
    rv32i_control dec_ctrl;
    logic         dec_illegal;

    assign dec_opcode = in_instr[6:0];
    assign dec_funct3 = in_instr[14:12];
    assign dec_funct7 = in_instr[31:25];

    // Decode the incoming instruction; illegal encodings collapse to a
    // control word carrying only opcode/funct3 so nothing downstream fires.
    always_comb begin
        dec_illegal             = 1'b0;
        dec_ctrl                = '0;
        dec_ctrl.opcode         = dec_opcode;
        dec_ctrl.funct3         = dec_funct3;
        dec_ctrl.aluop          = dec_funct3;
        dec_ctrl.cmpop          = CMP_BEQ;
        dec_ctrl.alumux1_sel    = ALUMUX1_RS1;
        dec_ctrl.alumux2_sel    = ALUMUX2_I;
        dec_ctrl.cmpmux_sel     = CMPMUX_RS2;
        dec_ctrl.regfilemux_sel = RFMUX_ALU;
        dec_ctrl.icache_read    = 1'b1;

        case (dec_opcode)
            OP_LUI: begin
                dec_ctrl.load_regfile   = 1'b1;
                dec_ctrl.regfilemux_sel = RFMUX_U_IMM;
            end
            OP_AUIPC: begin
                dec_ctrl.aluop        = ALU_ADD;
                dec_ctrl.alumux1_sel  = ALUMUX1_PC;
                dec_ctrl.alumux2_sel  = ALUMUX2_U;
                dec_ctrl.load_regfile = 1'b1;
            end
            OP_JAL: begin
                dec_ctrl.aluop          = ALU_ADD;
                dec_ctrl.alumux1_sel    = ALUMUX1_PC;
                dec_ctrl.alumux2_sel    = ALUMUX2_J;
                dec_ctrl.regfilemux_sel = RFMUX_PC4;
                dec_ctrl.load_regfile   = 1'b1;
                dec_ctrl.jal_enable     = 1'b1;
            end
            OP_JALR: begin
                dec_ctrl.aluop          = ALU_ADD;
                dec_ctrl.regfilemux_sel = RFMUX_PC4;
                dec_ctrl.load_regfile   = 1'b1;
                dec_ctrl.jalr_enable    = 1'b1;
            end
            OP_BR: begin
                if (dec_funct3 == 3'b010 || dec_funct3 == 3'b011) begin
                    dec_illegal = 1'b1;
                end
                dec_ctrl.cmpop         = dec_funct3;
                dec_ctrl.aluop         = ALU_ADD;
                dec_ctrl.alumux1_sel   = ALUMUX1_PC;
                dec_ctrl.alumux2_sel   = ALUMUX2_B;
                dec_ctrl.branch_enable = 1'b1;
            end
            OP_LOAD: begin
                dec_ctrl.aluop        = ALU_ADD;
                dec_ctrl.dcache_read  = 1'b1;
                dec_ctrl.load_regfile = 1'b1;
                case (dec_funct3)
                    3'b000:  dec_ctrl.regfilemux_sel = RFMUX_LB;
                    3'b001:  dec_ctrl.regfilemux_sel = RFMUX_LH;
                    3'b010:  dec_ctrl.regfilemux_sel = RFMUX_LW;
                    3'b100:  dec_ctrl.regfilemux_sel = RFMUX_LBU;
                    3'b101:  dec_ctrl.regfilemux_sel = RFMUX_LHU;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_STORE: begin
                if (dec_funct3 > 3'b010) begin
                    dec_illegal = 1'b1;
                end
                dec_ctrl.aluop        = ALU_ADD;
                dec_ctrl.alumux2_sel  = ALUMUX2_S;
                dec_ctrl.dcache_write = 1'b1;
            end
            OP_IMM: begin
                dec_ctrl.load_regfile = 1'b1;
                case (dec_funct3)
                    3'b001: begin
                        // slli carries no funct7 variants
                        if (dec_funct7 != 7'b0000000) begin
                            dec_illegal = 1'b1;
                        end
                    end
                    3'b101: begin
                        if (dec_funct7 == 7'b0100000) begin
                            dec_ctrl.aluop = ALU_SRA;
                        end else if (dec_funct7 != 7'b0000000) begin
                            dec_illegal = 1'b1;
                        end
                    end
                    3'b010, 3'b011: begin
                        dec_ctrl.cmpop          = (dec_funct3 == 3'b010) ? CMP_BLT : CMP_BLTU;
                        dec_ctrl.cmpmux_sel     = CMPMUX_I;
                        dec_ctrl.regfilemux_sel = RFMUX_BR_EN;
                        dec_ctrl.forward_cmp    = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_REG: begin
                dec_ctrl.load_regfile = 1'b1;
                dec_ctrl.alumux2_sel  = ALUMUX2_RS2;
                if (dec_funct7 == 7'b0000001) begin
                    if (M_EXT != 0) begin
                        dec_ctrl.m_enable = 1'b1;
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end else if (dec_funct7 == 7'b0100000) begin
                    // Only add->sub and srl->sra have an alternate form
                    if (dec_funct3 == 3'b000) begin
                        dec_ctrl.aluop = ALU_SUB;
                    end else if (dec_funct3 == 3'b101) begin
                        dec_ctrl.aluop = ALU_SRA;
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end else if (dec_funct7 == 7'b0000000) begin
                    if (dec_funct3 == 3'b010 || dec_funct3 == 3'b011) begin
                        dec_ctrl.cmpop          = (dec_funct3 == 3'b010) ? CMP_BLT : CMP_BLTU;
                        dec_ctrl.cmpmux_sel     = CMPMUX_RS2;
                        dec_ctrl.regfilemux_sel = RFMUX_BR_EN;
                        dec_ctrl.forward_cmp    = 1'b1;
                    end
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: dec_illegal = 1'b1;
        endcase

        if (dec_illegal) begin
            dec_ctrl        = '0;
            dec_ctrl.opcode = dec_opcode;
            dec_ctrl.funct3 = dec_funct3;
        end
    end

    // ------------------------------------------------------------------
    // Queue control
    // ------------------------------------------------------------------
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          do_push;
    logic          do_pop;

    assign in_ready  = (count_q != FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    // Flush dominates, so handshakes that coincide with it are discarded.
    assign do_push = in_valid  & in_ready  & ~flush;
    assign do_pop  = out_valid & out_ready & ~flush;

    // Next pointer/occupancy; pointers wrap naturally since DEPTH is 2^PW.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    rv32i_control    ctrl_mem_q  [DEPTH];
    logic [31:0]     instr_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic            ill_mem_q   [DEPTH];

    // Capture the decoded entry at the write pointer on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_mem_q[i]  <= '0;
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
                ill_mem_q[i]   <= 1'b0;
            end
        end else if (do_push) begin
            ctrl_mem_q[wr_ptr_q]  <= dec_ctrl;
            instr_mem_q[wr_ptr_q] <= in_instr;
            pc_mem_q[wr_ptr_q]    <= in_pc;
            ill_mem_q[wr_ptr_q]   <= dec_illegal;
        end
    end

    // Head outputs come straight from storage and read as zero when empty.
    assign out_ctrl    = out_valid ? ctrl_mem_q[rd_ptr_q]  : '0;
    assign out_instr   = out_valid ? instr_mem_q[rd_ptr_q] : '0;
    assign out_pc      = out_valid ? pc_mem_q[rd_ptr_q]    : '0;
    assign out_illegal = out_valid ? ill_mem_q[rd_ptr_q]   : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_queue
//  Purpose  : Self-checking bench for decode_queue; directed scenarios plus
//             randomized traffic against a queue/rule-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int CW    = $clog2(DEPTH+1);
    localparam int CTW   = $bits(rv32i_control);

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;
    logic             out_ready;

    logic             in_ready,    m0_in_ready;
    logic             out_valid,   m0_out_valid;
    logic [CTW-1:0]   out_ctrl,    m0_out_ctrl;
    logic [31:0]      out_instr,   m0_out_instr;
    logic [XLEN-1:0]  out_pc,      m0_out_pc;
    logic             out_illegal, m0_out_illegal;
    logic [CW-1:0]    count,       m0_count;

    rv32i_control oc;
    assign oc = out_ctrl;

    decode_queue #(.DEPTH(DEPTH), .M_EXT(1), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_instr(out_instr), .out_pc(out_pc), .out_illegal(out_illegal), .count(count)
    );

    decode_queue #(.DEPTH(DEPTH), .M_EXT(0), .XLEN(XLEN)) dut_m0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(m0_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(m0_out_valid), .out_ready(out_ready), .out_ctrl(m0_out_ctrl),
        .out_instr(m0_out_instr), .out_pc(m0_out_pc), .out_illegal(m0_out_illegal), .count(m0_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: instruction classes and the control word each implies
    // ------------------------------------------------------------------
    typedef enum int {K_LUI, K_AUIPC, K_JAL, K_JALR, K_BR, K_LOAD, K_STORE,
                      K_ALU_I, K_SLT_I, K_ALU_R, K_SLT_R, K_MUL, K_BAD} kind_t;

    function automatic kind_t classify(input logic [31:0] ins, input bit mext);
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        case (op)
            7'b0110111: return K_LUI;
            7'b0010111: return K_AUIPC;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            7'b1100011: return (f3 inside {3'd2, 3'd3}) ? K_BAD : K_BR;
            7'b0000011: return (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ? K_LOAD : K_BAD;
            7'b0100011: return (f3 <= 3'd2) ? K_STORE : K_BAD;
            7'b0010011: begin
                if (f3 == 3'd1 && f7 != 7'h00) return K_BAD;
                if (f3 == 3'd5 && !(f7 inside {7'h00, 7'h20})) return K_BAD;
                return (f3 inside {3'd2, 3'd3}) ? K_SLT_I : K_ALU_I;
            end
            7'b0110011: begin
                if (f7 == 7'h01) return mext ? K_MUL : K_BAD;
                if (f7 == 7'h00) return (f3 inside {3'd2, 3'd3}) ? K_SLT_R : K_ALU_R;
                if (f7 == 7'h20 && (f3 inside {3'd0, 3'd5})) return K_ALU_R;
                return K_BAD;
            end
            default: return K_BAD;
        endcase
    endfunction

    function automatic rv32i_control ref_ctrl(input logic [31:0] ins, input bit mext);
        rv32i_control c;
        kind_t        k  = classify(ins, mext);
        logic [2:0]   f3 = ins[14:12];
        logic [6:0]   f7 = ins[31:25];
        logic [3:0]   ld_sel [8];
        ld_sel = '{RFMUX_LB, RFMUX_LH, RFMUX_LW, 4'd0, RFMUX_LBU, RFMUX_LHU, 4'd0, 4'd0};
        c        = '0;
        c.opcode = ins[6:0];
        c.funct3 = f3;
        if (k == K_BAD) return c;
        c.icache_read = 1'b1;
        c.aluop       = f3;
        // address-style computations are adds of the listed operands
        if (k inside {K_AUIPC, K_JAL, K_JALR, K_BR, K_LOAD, K_STORE}) c.aluop = ALU_ADD;
        if (k inside {K_AUIPC, K_JAL, K_BR}) c.alumux1_sel = ALUMUX1_PC;
        case (k)
            K_AUIPC: c.alumux2_sel = ALUMUX2_U;
            K_JAL:   c.alumux2_sel = ALUMUX2_J;
            K_BR:    c.alumux2_sel = ALUMUX2_B;
            K_STORE: c.alumux2_sel = ALUMUX2_S;
            K_ALU_R, K_SLT_R, K_MUL: c.alumux2_sel = ALUMUX2_RS2;
            default: c.alumux2_sel = ALUMUX2_I;
        endcase
        c.load_regfile = !(k inside {K_BR, K_STORE});
        case (k)
            K_LUI:            c.regfilemux_sel = RFMUX_U_IMM;
            K_JAL, K_JALR:    c.regfilemux_sel = RFMUX_PC4;
            K_LOAD:           c.regfilemux_sel = ld_sel[f3];
            K_SLT_I, K_SLT_R: c.regfilemux_sel = RFMUX_BR_EN;
            default:          c.regfilemux_sel = RFMUX_ALU;
        endcase
        c.jal_enable    = (k == K_JAL);
        c.jalr_enable   = (k == K_JALR);
        c.branch_enable = (k == K_BR);
        c.dcache_read   = (k == K_LOAD);
        c.dcache_write  = (k == K_STORE);
        c.m_enable      = (k == K_MUL);
        if (k == K_BR) c.cmpop = f3;
        if (k inside {K_SLT_I, K_SLT_R}) begin
            c.cmpop       = (f3 == 3'd2) ? CMP_BLT : CMP_BLTU;
            c.cmpmux_sel  = (k == K_SLT_I) ? CMPMUX_I : CMPMUX_RS2;
            c.forward_cmp = 1'b1;
        end
        if (k == K_ALU_I && f3 == 3'd5 && f7 == 7'h20) c.aluop = ALU_SRA;
        if (k == K_ALU_R && f7 == 7'h20) c.aluop = (f3 == 3'd0) ? ALU_SUB : ALU_SRA;
        return c;
    endfunction

    typedef struct {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } ent_t;
    ent_t mq[$];

    // Compare every observable output of both instances against the model.
    task automatic check_outputs();
        rv32i_control e1, e0;
        ent_t         h;
        bit           empty = (mq.size() == 0);
        check("count",     64'(count),     64'(mq.size()));
        check("out_valid", 64'(out_valid), 64'(!empty));
        check("in_ready",  64'(in_ready),  64'(mq.size() != DEPTH));
        check("m0_count",  64'(m0_count),  64'(mq.size()));
        if (empty) begin
            check("out_ctrl_empty",  64'(out_ctrl),    64'd0);
            check("out_instr_empty", 64'(out_instr),   64'd0);
            check("out_pc_empty",    64'(out_pc),      64'd0);
            check("out_ill_empty",   64'(out_illegal), 64'd0);
        end else begin
            h  = mq[0];
            e1 = ref_ctrl(h.instr, 1'b1);
            e0 = ref_ctrl(h.instr, 1'b0);
            check("out_ctrl",    64'(out_ctrl),       64'(e1));
            check("out_instr",   64'(out_instr),      64'(h.instr));
            check("out_pc",      64'(out_pc),         64'(h.pc));
            check("out_illegal", 64'(out_illegal),    64'(classify(h.instr, 1'b1) == K_BAD));
            check("m0_ctrl",     64'(m0_out_ctrl),    64'(e0));
            check("m0_illegal",  64'(m0_out_illegal), 64'(classify(h.instr, 1'b0) == K_BAD));
        end
    endtask

    logic [XLEN-1:0] pc_ctr = 32'h0000_1000;

    // One clock: drive inputs, check pre-edge outputs, advance the model.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
        bit   can_push, can_pop;
        ent_t e;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc_ctr;
        out_ready = rdy;
        flush     = fl;
        @(negedge clk);
        check_outputs();
        can_push = v && (mq.size() != DEPTH);
        can_pop  = rdy && (mq.size() != 0);
        if (fl) begin
            mq.delete();
        end else begin
            if (can_pop) void'(mq.pop_front());
            if (can_push) begin
                e.instr = ins;
                e.pc    = pc_ctr;
                mq.push_back(e);
            end
        end
        if (v) pc_ctr = pc_ctr + 32'd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic async_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [11];
        logic [6:0]  f7s [4];
        logic [31:0] w;
        ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LOAD, OP_STORE,
                OP_IMM, OP_REG, OP_CSR, 7'h7F};
        f7s = '{7'h00, 7'h20, 7'h01, 7'h00};
        w = $urandom;
        if ($urandom_range(0, 9) == 0) return w;
        w[6:0] = ops[$urandom_range(0, 10)];
        f7s[3] = 7'($urandom);
        w[31:25] = f7s[$urandom_range(0, 3)];
        return w;
    endfunction

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        #12;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: addi x1,x0,5 visible one cycle after push
        cycle(1'b1, 32'h0050_0093, 1'b0, 1'b0);
        check("t1_valid", 64'(out_valid),       64'd1);
        check("t1_aluop", 64'(oc.aluop),        64'(ALU_ADD));
        check("t1_load",  64'(oc.load_regfile), 64'd1);
        check("t1_count", 64'(count),           64'd1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // 2: fill, blocked push while popping at full, drain with wrap
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h0000_0013 | (32'(i) << 20), 1'b0, 1'b0);
        check("t2_in_ready", 64'(in_ready), 64'd0);
        cycle(1'b1, 32'h0070_0093, 1'b1, 1'b0);
        check("t2_count_after_blocked", 64'(count), 64'(DEPTH - 1));
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // 3: steady push+pop at count=2
        cycle(1'b1, 32'h0010_0113, 1'b0, 1'b0);
        cycle(1'b1, 32'h0020_0113, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 32'h4020_81B3 ^ (32'(i) << 7), 1'b1, 1'b0);
            check("t3_count", 64'(count), 64'd2);
        end
        for (int i = 0; i < 2; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // 4: illegal all-ones word between legal ones
        cycle(1'b1, 32'h0000_A083, 1'b0, 1'b0);
        cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("t4_illegal", 64'(out_illegal),     64'd1);
        check("t4_load",    64'(oc.load_regfile), 64'd0);
        check("t4_dc_rw",   64'({oc.dcache_read, oc.dcache_write}), 64'd0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // 5: mul x3,x1,x2 under both M_EXT settings
        cycle(1'b1, 32'h0220_81B3, 1'b0, 1'b0);
        check("t5_m_enable",  64'(oc.m_enable),     64'd1);
        check("t5_illegal",   64'(out_illegal),     64'd0);
        check("t5_m0_illegal", 64'(m0_out_illegal), 64'd1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // 6: flush with a simultaneous push, then async reset mid-stream
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h0000_0033, 1'b0, 1'b0);
        cycle(1'b1, 32'h0050_0093, 1'b1, 1'b1);
        check("t6_flush_count", 64'(count),     64'd0);
        check("t6_flush_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h0000_0037, 1'b0, 1'b0);
        async_reset();
        check("t6_rst_count", 64'(count), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if (n == 300) async_reset();
            cycle(($urandom_range(0, 9) < 7), rand_instr(),
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 39) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
